// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: oversampled start detect, mid-bit sampling,
// framing-error and overrun reporting toward a single-byte consumer.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic       ack,
  output logic [7:0] rx_data,
  output logic       data_valid,
  output logic       busy,
  output logic       framing_error,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          count_q, count_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   held_q, held_d;

  logic s_in;
  logic cnt_mid;
  logic cnt_end;

  assign s_in    = sync_q[SYNC_STAGES-1];
  assign cnt_mid = (count_q == CW'(CLKS_PER_BIT/2 - 1));
  assign cnt_end = (count_q == CW'(CLKS_PER_BIT - 1));

  // Shift toward the MSB; bit 0 takes the raw asynchronous line.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], data_in};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = ovr_q;
    held_d    = held_q;

    if (ack) begin
      held_d = 1'b0;
      ovr_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (!s_in) begin
          state_d = S_START;
        end
      end

      S_START: begin
        count_d = count_q + 1'b1;
        if (cnt_mid) begin
          count_d   = '0;
          bit_idx_d = '0;
          state_d   = s_in ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        count_d = count_q + 1'b1;
        if (cnt_end) begin
          count_d            = '0;
          shift_d[bit_idx_q] = s_in;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        count_d = count_q + 1'b1;
        if (cnt_end) begin
          count_d = '0;
          if (s_in) begin
            rx_data_d = shift_q;
            valid_d   = 1'b1;
            // A fresh byte beats a same-cycle ack.
            ovr_d     = held_q && !ack;
            held_d    = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        count_d = '0;
        if (s_in) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync_q    <= '1;
      count_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      held_q    <= held_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: latency, back-to-back, glitch,
// break, mid-frame reset and a behavioural-transmitter loopback.
module tb_uart_receiver;

  localparam int C  = 16;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       ack;
  logic [7:0] rx_data;
  logic       data_valid;
  logic       busy;
  logic       framing_error;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  int   cyc = 0;
  int   dv_cyc[$];
  logic [7:0] dv_dat[$];
  int   fe_cnt = 0;
  int   busy_cnt = 0;
  bit   both_hi = 1'b0;

  uart_receiver #(
    .CLKS_PER_BIT(C),
    .SYNC_STAGES (SS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .ack          (ack),
    .rx_data      (rx_data),
    .data_valid   (data_valid),
    .busy         (busy),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cyc.push_back(cyc);
      dv_dat.push_back(rx_data);
    end
    if (framing_error) fe_cnt++;
    if (busy) busy_cnt++;
    if (data_valid && framing_error) both_hi = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    data_in = v;
    repeat (C) tick();
  endtask

  // Behavioural 8N1 transmitter, LSB first.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  int t0;
  int n0;
  int f0;
  int b0;

  initial begin
    rst     = 1'b1;
    data_in = 1'b1;
    ack     = 1'b0;
    repeat (3) tick();
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ferr", {31'd0, framing_error}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Single frame 0xAA: latency 2+144+8+1 = 155.
    n0 = dv_cyc.size();
    f0 = fe_cnt;
    t0 = cyc;
    send_frame(8'hAA, 1'b1);
    send_bit(1'b1);
    check("aa_count", dv_cyc.size() - n0, 32'd1);
    check("aa_latency", dv_cyc[n0] - t0, 32'd155);
    check("aa_rx_data", {24'd0, rx_data}, 32'hAA);
    check("aa_ferr", fe_cnt - f0, 32'd0);
    check("aa_busy", {31'd0, busy}, 32'd0);
    check("aa_ovr", {31'd0, overrun}, 32'd0);
    pulse_ack();

    // Back-to-back 0xAA, 0xCC with no ack.
    n0 = dv_cyc.size();
    t0 = cyc;
    send_frame(8'hAA, 1'b1);
    send_frame(8'hCC, 1'b1);
    send_bit(1'b1);
    check("b2b_count", dv_cyc.size() - n0, 32'd2);
    check("b2b_lat", dv_cyc[n0] - t0, 32'd155);
    check("b2b_gap", dv_cyc[n0+1] - dv_cyc[n0], 32'd160);
    check("b2b_first", {24'd0, dv_dat[n0]}, 32'hAA);
    check("b2b_rx_data", {24'd0, rx_data}, 32'hCC);
    check("b2b_ovr", {31'd0, overrun}, 32'd1);
    pulse_ack();
    check("b2b_ack_ovr", {31'd0, overrun}, 32'd0);

    // 3-cycle glitch, then a good 0x55.
    n0 = dv_cyc.size();
    f0 = fe_cnt;
    b0 = busy_cnt;
    data_in = 1'b0;
    repeat (3) tick();
    data_in = 1'b1;
    repeat (20) tick();
    check("gl_valid", dv_cyc.size() - n0, 32'd0);
    check("gl_ferr", fe_cnt - f0, 32'd0);
    check("gl_busy_rng", {31'd0, (busy_cnt - b0 >= 1) && (busy_cnt - b0 <= 8)}, 32'd1);
    check("gl_busy_now", {31'd0, busy}, 32'd0);
    send_frame(8'h55, 1'b1);
    send_bit(1'b1);
    check("gl_55_count", dv_cyc.size() - n0, 32'd1);
    check("gl_55_data", {24'd0, rx_data}, 32'h55);
    pulse_ack();

    // 0x3C with low stop, line held low 40 bit times.
    n0 = dv_cyc.size();
    f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) send_bit(1'b0);
    check("brk_busy", {31'd0, busy}, 32'd1);
    check("brk_ferr", fe_cnt - f0, 32'd1);
    check("brk_valid", dv_cyc.size() - n0, 32'd0);
    check("brk_rx_data", {24'd0, rx_data}, 32'h55);
    data_in = 1'b1;
    repeat (6) tick();
    check("brk_release", {31'd0, busy}, 32'd0);
    check("brk_ferr_end", fe_cnt - f0, 32'd1);
    check("brk_excl", {31'd0, both_hi}, 32'd0);

    // Reset in the middle of 0xF0 data bits.
    n0 = dv_cyc.size();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rst = 1'b1;
    data_in = 1'b1;
    #1;
    check("mid_rst_rx", {24'd0, rx_data}, 32'h00);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
    check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    check("mid_rst_none", dv_cyc.size() - n0, 32'd0);
    send_frame(8'h0F, 1'b1);
    send_bit(1'b1);
    check("mid_rst_0f_n", dv_cyc.size() - n0, 32'd1);
    check("mid_rst_0f", {24'd0, rx_data}, 32'h0F);
    pulse_ack();

    // Loopback from the transmitter model.
    n0 = dv_cyc.size();
    f0 = fe_cnt;
    send_frame(8'h00, 1'b1);
    pulse_ack();
    send_frame(8'hFF, 1'b1);
    pulse_ack();
    send_frame(8'hA5, 1'b1);
    send_bit(1'b1);
    check("lb_count", dv_cyc.size() - n0, 32'd3);
    check("lb_b0", {24'd0, dv_dat[n0]}, 32'h00);
    check("lb_b1", {24'd0, dv_dat[n0+1]}, 32'hFF);
    check("lb_b2", {24'd0, dv_dat[n0+2]}, 32'hA5);
    check("lb_ferr", fe_cnt - f0, 32'd0);
    check("lb_ovr", {31'd0, overrun}, 32'd0);
    check("excl_final", {31'd0, both_hi}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
